// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad front end (interfaz_teclado).
// Optional build macro used by the top: TECLADO_TIMEOUT_EN.
package teclado_pkg;

    localparam int MONTO_W = 32;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_EMIT         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } estado_t;

    localparam logic [3:0] KEY_A         = 4'hA;
    localparam logic [3:0] KEY_B         = 4'hB;
    localparam logic [3:0] KEY_C         = 4'hC;
    localparam logic [3:0] KEY_D         = 4'hD;
    localparam logic [3:0] KEY_ASTERISCO = 4'hE;
    localparam logic [3:0] KEY_NUMERAL   = 4'hF;

    // Map a (row, column) position to its key code.
    function automatic logic [3:0] decodificar(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'h0:    codigo = 4'd1;
            4'h1:    codigo = 4'd2;
            4'h2:    codigo = 4'd3;
            4'h3:    codigo = KEY_A;
            4'h4:    codigo = 4'd4;
            4'h5:    codigo = 4'd5;
            4'h6:    codigo = 4'd6;
            4'h7:    codigo = KEY_B;
            4'h8:    codigo = 4'd7;
            4'h9:    codigo = 4'd8;
            4'hA:    codigo = 4'd9;
            4'hB:    codigo = KEY_C;
            4'hC:    codigo = KEY_ASTERISCO;
            4'hD:    codigo = 4'd0;
            4'hE:    codigo = KEY_NUMERAL;
            4'hF:    codigo = KEY_D;
            default: codigo = KEY_D;
        endcase
        return codigo;
    endfunction

    function automatic logic [2:0] contar_ceros(input logic [3:0] cols);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!cols[i]) begin
                n = n + 3'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Index of the lowest low column; only meaningful when exactly one is low.
    function automatic logic [1:0] columna_activa(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0]) begin
            idx = 2'd0;
        end else if (!cols[1]) begin
            idx = 2'd1;
        end else if (!cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic es_digito(input logic [3:0] codigo);
        return (codigo <= 4'd9);
    endfunction

endpackage

// File: rtl/acumulador_monto.sv
// Decimal amount accumulator: pushes digits into a binary value, commits it
// on request and flags digits rejected once the digit limit is reached.
module acumulador_monto
    import teclado_pkg::*;
#(
    parameter int MAX_DIGITOS = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [3:0]         digito,
    input  logic               commit,
    input  logic               clear,
    output logic [MONTO_W-1:0] monto,
    output logic               monto_stb,
    output logic               desborde_stb,
    output logic               hay_digitos
);

    localparam int CW = $clog2(MAX_DIGITOS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITOS);

    logic [MONTO_W-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [MONTO_W-1:0] monto_r;
    logic               monto_stb_r;
    logic               desborde_r;
    logic [MONTO_W-1:0] acc_x10_s;

    // acc*10 + d built from shifts so no multiplier is inferred.
    assign acc_x10_s = (acc_r << 3) + (acc_r << 1) + {{(MONTO_W-4){1'b0}}, digito};

    // Accumulator, digit count and registered commit/overflow strobes; clear wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r       <= {MONTO_W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            monto_r     <= {MONTO_W{1'b0}};
            monto_stb_r <= 1'b0;
            desborde_r  <= 1'b0;
        end else begin
            monto_stb_r <= 1'b0;
            desborde_r  <= 1'b0;
            if (clear) begin
                acc_r <= {MONTO_W{1'b0}};
                cnt_r <= {CW{1'b0}};
            end else if (push) begin
                if (cnt_r < MAX_CNT) begin
                    acc_r <= acc_x10_s;
                    cnt_r <= cnt_r + CW'(1'b1);
                end else begin
                    desborde_r <= 1'b1;
                end
            end else if (commit && (cnt_r != {CW{1'b0}})) begin
                monto_r     <= acc_r;
                monto_stb_r <= 1'b1;
                acc_r       <= {MONTO_W{1'b0}};
                cnt_r       <= {CW{1'b0}};
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign monto        = monto_r;
    assign monto_stb    = monto_stb_r;
    assign desborde_stb = desborde_r;
    assign hay_digitos  = (cnt_r != {CW{1'b0}});

endmodule

// File: rtl/interfaz_teclado.sv
// 4x4 keypad scanner/debouncer with PIN digit and decimal amount outputs.
// Optional build macro TECLADO_TIMEOUT_EN clears a stale partial amount.
module interfaz_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITOS     = 9,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [3:0]         filas,
    input  logic [3:0]         columnas,
    input  logic               modo_monto,
    output logic [3:0]         digito,
    output logic               digito_stb,
    output logic [MONTO_W-1:0] monto,
    output logic               monto_stb,
    output logic               error_desborde
);

    localparam int SCW = $clog2(SCAN_CYCLES + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SCW-1:0] SCAN_ULT = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_ULT  = DBW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]     col_meta_r, col_sync_r;
    estado_t        estado_r, estado_s;
    logic [1:0]     fila_r, fila_s, lat_fila_r, lat_fila_s;
    logic [3:0]     lat_pat_r, lat_pat_s, filas_r;
    logic [SCW-1:0] scan_cnt_r, scan_cnt_s;
    logic [DBW-1:0] deb_cnt_r, deb_cnt_s;
    logic [1:0]     tag1_fila_r, tag2_fila_r;
    logic           tag1_ult_r, tag2_ult_r, ult_s, tag_ok_s;
    logic [3:0]     digito_r, digito_s, codigo_s;
    logic           digito_stb_r, digito_stb_s;
    logic           modo_prev_r, cambio_modo_s;
    logic           emit_s, push_s, commit_s, borrar_tecla_s, clear_s, timeout_s;
    logic           hay_digitos_s;
    logic [2:0]     n_ceros_s;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= columnas;
            col_sync_r <= col_meta_r;
        end
    end

    // The tag pipeline follows the synchronizer, so col_sync_r is always
    // attributed to the row that was actually driven when it was captured.
    assign tag_ok_s      = (tag2_fila_r == lat_fila_r);
    assign n_ceros_s     = contar_ceros(col_sync_r);
    assign codigo_s      = decodificar(lat_fila_r, columna_activa(lat_pat_r));
    assign cambio_modo_s = modo_monto ^ modo_prev_r;
    assign clear_s       = cambio_modo_s | timeout_s | borrar_tecla_s;

    // Next-state, row rotation, debounce counting and EMIT decode.
    always_comb begin
        estado_s       = estado_r;
        fila_s         = fila_r;
        scan_cnt_s     = scan_cnt_r;
        deb_cnt_s      = deb_cnt_r;
        lat_fila_s     = lat_fila_r;
        lat_pat_s      = lat_pat_r;
        ult_s          = 1'b0;
        digito_s       = digito_r;
        digito_stb_s   = 1'b0;
        emit_s         = 1'b0;
        push_s         = 1'b0;
        commit_s       = 1'b0;
        borrar_tecla_s = 1'b0;
        case (estado_r)
            ST_SCAN: begin
                if (scan_cnt_r == SCAN_ULT) begin
                    ult_s      = 1'b1;
                    scan_cnt_s = {SCW{1'b0}};
                    fila_s     = fila_r + 2'd1;
                end else begin
                    scan_cnt_s = scan_cnt_r + SCW'(1'b1);
                end
                if (tag2_ult_r && (n_ceros_s == 3'd1)) begin
                    lat_fila_s = tag2_fila_r;
                    lat_pat_s  = col_sync_r;
                    fila_s     = tag2_fila_r;
                    scan_cnt_s = {SCW{1'b0}};
                    deb_cnt_s  = {DBW{1'b0}};
                    estado_s   = ST_DEBOUNCE;
                end else if (tag2_ult_r && (n_ceros_s > 3'd1)) begin
                    lat_fila_s = tag2_fila_r;
                    fila_s     = tag2_fila_r;
                    scan_cnt_s = {SCW{1'b0}};
                    deb_cnt_s  = {DBW{1'b0}};
                    estado_s   = ST_WAIT_RELEASE;
                end else begin
                    estado_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (!tag_ok_s) begin
                    deb_cnt_s = deb_cnt_r;
                end else if (col_sync_r != lat_pat_r) begin
                    fila_s     = lat_fila_r + 2'd1;
                    scan_cnt_s = {SCW{1'b0}};
                    estado_s   = ST_SCAN;
                end else if (deb_cnt_r == DEB_ULT) begin
                    deb_cnt_s = {DBW{1'b0}};
                    estado_s  = ST_EMIT;
                end else begin
                    deb_cnt_s = deb_cnt_r + DBW'(1'b1);
                end
            end
            ST_EMIT: begin
                emit_s    = 1'b1;
                deb_cnt_s = {DBW{1'b0}};
                estado_s  = ST_WAIT_RELEASE;
                if (modo_monto) begin
                    if (es_digito(codigo_s)) begin
                        push_s = 1'b1;
                    end else if (codigo_s == KEY_NUMERAL) begin
                        commit_s = 1'b1;
                    end else if (codigo_s == KEY_ASTERISCO) begin
                        borrar_tecla_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                end else begin
                    if (es_digito(codigo_s)) begin
                        digito_s     = codigo_s;
                        digito_stb_s = 1'b1;
                    end else begin
                        digito_stb_s = 1'b0;
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (!tag_ok_s) begin
                    deb_cnt_s = deb_cnt_r;
                end else if (col_sync_r != 4'hF) begin
                    deb_cnt_s = {DBW{1'b0}};
                end else if (deb_cnt_r == DEB_ULT) begin
                    deb_cnt_s  = {DBW{1'b0}};
                    fila_s     = lat_fila_r + 2'd1;
                    scan_cnt_s = {SCW{1'b0}};
                    estado_s   = ST_SCAN;
                end else begin
                    deb_cnt_s = deb_cnt_r + DBW'(1'b1);
                end
            end
            default: begin
                estado_s = ST_SCAN;
            end
        endcase
    end

    // FSM, scan, latch and PIN output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_r     <= ST_SCAN;
            fila_r       <= 2'd0;
            filas_r      <= 4'b1110;
            scan_cnt_r   <= {SCW{1'b0}};
            deb_cnt_r    <= {DBW{1'b0}};
            lat_fila_r   <= 2'd0;
            lat_pat_r    <= 4'hF;
            tag1_fila_r  <= 2'd0;
            tag2_fila_r  <= 2'd0;
            tag1_ult_r   <= 1'b0;
            tag2_ult_r   <= 1'b0;
            digito_r     <= 4'd0;
            digito_stb_r <= 1'b0;
            modo_prev_r  <= modo_monto;
        end else begin
            estado_r     <= estado_s;
            fila_r       <= fila_s;
            filas_r      <= ~(4'b0001 << fila_s);
            scan_cnt_r   <= scan_cnt_s;
            deb_cnt_r    <= deb_cnt_s;
            lat_fila_r   <= lat_fila_s;
            lat_pat_r    <= lat_pat_s;
            tag1_fila_r  <= fila_r;
            tag2_fila_r  <= tag1_fila_r;
            tag1_ult_r   <= ult_s;
            tag2_ult_r   <= tag1_ult_r;
            digito_r     <= digito_s;
            digito_stb_r <= digito_stb_s;
            modo_prev_r  <= modo_monto;
        end
    end

`ifdef TECLADO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] inactivo_r;

    // Cycles since the last EMIT, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inactivo_r <= {TW{1'b0}};
        end else if (emit_s) begin
            inactivo_r <= {TW{1'b0}};
        end else if (inactivo_r != TIMEOUT_MAX) begin
            inactivo_r <= inactivo_r + TW'(1'b1);
        end else begin
            inactivo_r <= inactivo_r;
        end
    end

    assign timeout_s = (inactivo_r == TIMEOUT_MAX) && modo_monto && hay_digitos_s && !emit_s;
`else
    logic [31:0] timeout_unused_s;
    assign timeout_unused_s = {TIMEOUT_CYCLES[30:0], hay_digitos_s};
    assign timeout_s        = 1'b0;
`endif

    acumulador_monto #(
        .MAX_DIGITOS (MAX_DIGITOS)
    ) u_acumulador (
        .clk          (clk),
        .rst          (rst),
        .push         (push_s),
        .digito       (codigo_s),
        .commit       (commit_s),
        .clear        (clear_s),
        .monto        (monto),
        .monto_stb    (monto_stb),
        .desborde_stb (error_desborde),
        .hay_digitos  (hay_digitos_s)
    );

    assign filas      = filas_r;
    assign digito     = digito_r;
    assign digito_stb = digito_stb_r;

endmodule

// File: tb/tb_interfaz_teclado.sv
// Directed bench for interfaz_teclado with a behavioural 4x4 keypad model.
// Build with TECLADO_TIMEOUT_EN to also exercise the inactivity timeout.
module tb_interfaz_teclado;

`ifdef TECLADO_TIMEOUT_EN
    localparam int TO_CYCLES = 50;
`else
    localparam int TO_CYCLES = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        modo_monto = 1'b0;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  digito;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic        error_desborde;
    logic [15:0] key_mask = 16'h0000;

    int checks = 0;
    int failures = 0;
    int n_dig = 0;
    int n_monto = 0;
    int n_err = 0;
    int n_multi = 0;
    int n_consec = 0;
    logic prev_any = 1'b0;
    logic [3:0] dig_q[$];

    interfaz_teclado #(
        .SCAN_CYCLES     (2),
        .DEBOUNCE_CYCLES (4),
        .MAX_DIGITOS     (9),
        .TIMEOUT_CYCLES  (TO_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .filas          (filas),
        .columnas       (columnas),
        .modo_monto     (modo_monto),
        .digito         (digito),
        .digito_stb     (digito_stb),
        .monto          (monto),
        .monto_stb      (monto_stb),
        .error_desborde (error_desborde)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        columnas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !filas[r]) columnas[c] = 1'b0;
            end
        end
    end

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (digito_stb === 1'b1) begin
            n_dig <= n_dig + 1;
            dig_q.push_back(digito);
        end
        if (monto_stb === 1'b1) n_monto <= n_monto + 1;
        if (error_desborde === 1'b1) n_err <= n_err + 1;
        if ((int'(digito_stb) + int'(monto_stb) + int'(error_desborde)) > 1) n_multi <= n_multi + 1;
        if (prev_any && (digito_stb | monto_stb | error_desborde)) n_consec <= n_consec + 1;
        prev_any <= digito_stb | monto_stb | error_desborde;
    end

    function automatic int pos(input int tecla);
        case (tecla)
            1: return 0;   2: return 1;   3: return 2;
            4: return 4;   5: return 5;   6: return 6;
            7: return 8;   8: return 9;   9: return 10;
            0: return 13;  14: return 12; 15: return 14;
            default: return 15;
        endcase
    endfunction

    task automatic pulsar(input int tecla, input int rebote, input int hold);
        int idx;
        idx = pos(tecla);
        for (int i = 0; i < rebote; i++) begin
            key_mask[idx] = (i % 2 == 0);
            @(negedge clk);
        end
        key_mask[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        key_mask[idx] = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (filas !== 4'b1110) begin failures++; $display("FAIL reset_filas: got %b expected 1110", filas); end
        checks++; if (digito !== 4'd0) begin failures++; $display("FAIL reset_digito: got %0d expected 0", digito); end
        checks++; if (monto !== 32'd0) begin failures++; $display("FAIL reset_monto: got %0d expected 0", monto); end
        checks++; if ({digito_stb, monto_stb} !== 2'b00) begin failures++; $display("FAIL reset_stb: got %b expected 00", {digito_stb, monto_stb}); end
        checks++; if (error_desborde !== 1'b0) begin failures++; $display("FAIL reset_desborde: got %b expected 0", error_desborde); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_pin();
        int bd, bm, bq;
        logic [3:0] exp_d[4];
        logic [3:0] got;
        exp_d = '{4'd6, 4'd5, 4'd3, 4'd3};
        bd = n_dig; bm = n_monto; bq = dig_q.size();
        for (int i = 0; i < 4; i++) pulsar(int'(exp_d[i]), 3, 50);
        checks++; if (n_dig - bd !== 4) begin failures++; $display("FAIL pin_count: got %0d expected 4", n_dig - bd); end
        for (int i = 0; i < 4; i++) begin
            got = (bq + i < dig_q.size()) ? dig_q[bq+i] : 4'hF;
            checks++; if (got !== exp_d[i]) begin failures++; $display("FAIL pin_digit%0d: got %0d expected %0d", i, got, exp_d[i]); end
        end
        checks++; if (n_monto - bm !== 0) begin failures++; $display("FAIL pin_no_monto: got %0d expected 0", n_monto - bm); end
    endtask

    task automatic test_amount_basic();
        int bd, bm;
        int seq[5];
        seq = '{2, 0, 0, 0, 15};
        modo_monto = 1'b1;
        repeat (5) @(negedge clk);
        bd = n_dig; bm = n_monto;
        for (int i = 0; i < 5; i++) pulsar(seq[i], 0, 50);
        checks++; if (n_monto - bm !== 1) begin failures++; $display("FAIL amt_stb: got %0d expected 1", n_monto - bm); end
        checks++; if (monto !== 32'd2000) begin failures++; $display("FAIL amt_value: got %0d expected 2000", monto); end
        checks++; if (n_dig - bd !== 0) begin failures++; $display("FAIL amt_no_digito: got %0d expected 0", n_dig - bd); end
    endtask

    task automatic test_amount_star();
        int bm;
        int seq[10];
        seq = '{6, 0, 0, 0, 0, 14, 2, 0, 15, 15};
        bm = n_monto;
        for (int i = 0; i < 10; i++) pulsar(seq[i], 0, 50);
        checks++; if (n_monto - bm !== 1) begin failures++; $display("FAIL star_stb: got %0d expected 1", n_monto - bm); end
        checks++; if (monto !== 32'd20) begin failures++; $display("FAIL star_value: got %0d expected 20", monto); end
    endtask

    task automatic test_overflow();
        int be, bm;
        be = n_err; bm = n_monto;
        for (int i = 0; i < 9; i++) pulsar(9, 0, 50);
        checks++; if (n_err - be !== 0) begin failures++; $display("FAIL ovf_early: got %0d expected 0", n_err - be); end
        pulsar(9, 0, 50);
        checks++; if (n_err - be !== 1) begin failures++; $display("FAIL ovf_tenth: got %0d expected 1", n_err - be); end
        pulsar(15, 0, 50);
        checks++; if (monto !== 32'd999999999) begin failures++; $display("FAIL ovf_value: got %0d expected 999999999", monto); end
        checks++; if (n_monto - bm !== 1) begin failures++; $display("FAIL ovf_stb: got %0d expected 1", n_monto - bm); end
    endtask

    task automatic test_hold();
        int bd;
        modo_monto = 1'b0;
        repeat (5) @(negedge clk);
        bd = n_dig;
        pulsar(5, 0, 200);
        checks++; if (n_dig - bd !== 1) begin failures++; $display("FAIL hold_count: got %0d expected 1", n_dig - bd); end
        checks++; if (digito !== 4'd5) begin failures++; $display("FAIL hold_digit: got %0d expected 5", digito); end
    endtask

    task automatic test_two_keys();
        int b;
        b = n_dig + n_monto + n_err;
        key_mask[0] = 1'b1;
        key_mask[1] = 1'b1;
        repeat (100) @(negedge clk);
        key_mask[0] = 1'b0;
        key_mask[1] = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (n_dig + n_monto + n_err - b !== 0) begin failures++; $display("FAIL two_keys: got %0d strobes expected 0", n_dig + n_monto + n_err - b); end
    endtask

    task automatic test_reset_debounce();
        int b, estable;
        logic [3:0] prev;
        logic hallado;
        b = n_dig + n_monto + n_err;
        hallado = 1'b0;
        estable = 0;
        prev = filas;
        key_mask[4] = 1'b1;
        for (int i = 0; i < 200 && !hallado; i++) begin
            @(negedge clk);
            if (filas === prev) estable++;
            else estable = 0;
            prev = filas;
            if (estable >= 2) hallado = 1'b1;
        end
        checks++; if (hallado !== 1'b1) begin failures++; $display("FAIL rstdeb_freeze: got %b expected 1", hallado); end
        rst = 1'b0;
        key_mask[4] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (n_dig + n_monto + n_err - b !== 0) begin failures++; $display("FAIL rstdeb_strobe: got %0d expected 0", n_dig + n_monto + n_err - b); end
    endtask

`ifdef TECLADO_TIMEOUT_EN
    task automatic test_timeout();
        modo_monto = 1'b1;
        repeat (5) @(negedge clk);
        pulsar(5, 0, 50);
        repeat (60) @(negedge clk);
        pulsar(1, 0, 50);
        pulsar(15, 0, 50);
        checks++; if (monto !== 32'd1) begin failures++; $display("FAIL timeout_value: got %0d expected 1", monto); end
    endtask
`endif

    initial begin
        test_reset();
        test_pin();
        test_amount_basic();
        test_amount_star();
        test_overflow();
        test_hold();
        test_two_keys();
        test_reset_debounce();
`ifdef TECLADO_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (n_multi !== 0) begin failures++; $display("FAIL strobe_overlap: got %0d expected 0", n_multi); end
        checks++; if (n_consec !== 0) begin failures++; $display("FAIL strobe_consecutive: got %0d expected 0", n_consec); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
